// File: rtl/sine_sweep_pkg.sv
// Shared constants for the sine-generator frequency-sweep scheduler:
// FSM state codes, register addresses and register bit positions.
package sine_sweep_pkg;

   localparam int FCW_W_DEF   = 8;
   localparam int DWELL_W_DEF = 16;
   localparam int CNT_W_DEF   = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DWELL = 2'd2;
   localparam logic [1:0] ST_STEP  = 2'd3;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_RANGE  = 2'd1;
   localparam logic [1:0] ADDR_DWELL  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   localparam int CTRL_CONT     = 2;
   localparam int CTRL_PINGPONG = 3;
   localparam int CTRL_IRQ_EN   = 4;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_CNT_CLR = 2;

endpackage

// File: rtl/sine_sweep_dwell_timer.sv
// Tick-paced dwell counter: o_expire pulses on the tick that completes
// max(i_dwell,1) ticks since the last clear or expiry.
module sine_sweep_dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clear,
   input  logic               i_en,
   input  logic               i_tick,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic               o_expire
);

   logic [DWELL_W-1:0] r_cnt;
   logic [DWELL_W-1:0] w_last;

   // A dwell of 0 behaves exactly like a dwell of 1.
   assign w_last   = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
   assign o_expire = i_en & i_tick & (r_cnt == w_last);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_en && i_tick) begin
         r_cnt <= o_expire ? '0 : r_cnt + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Avalon-mapped frequency-sweep scheduler: steps the generator fcw from
// start to stop at a tick-paced dwell rate, single-shot or continuous.
module sine_sweep_ctrl
   import sine_sweep_pkg::*;
#(
   parameter int FCW_W   = FCW_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ChipSelect,
   input  logic             Write,
   input  logic             Read,
   input  logic [1:0]       Address,
   input  logic [31:0]      WriteData,
   output logic [31:0]      ReadData,
   input  logic             tick,
   output logic [FCW_W-1:0] fcw,
   output logic             run,
   output logic             irq
);

   logic [1:0]         r_state;
   logic               r_cont;
   logic               r_pingpong;
   logic               r_irq_en;
   logic [FCW_W-1:0]   r_start_fcw;
   logic [FCW_W-1:0]   r_stop_fcw;
   logic [FCW_W-1:0]   r_step;
   logic [DWELL_W-1:0] r_dwell;
   logic               r_done;
   logic [CNT_W-1:0]   r_sweep_cnt;
   logic [FCW_W-1:0]   r_fcw;
   logic [FCW_W-1:0]   r_target;
   logic               r_dir;
   logic               r_run;
   logic [31:0]        r_rdata;

   logic               w_wr;
   logic               w_wr_ctrl;
   logic               w_wr_status;
   logic               w_start;
   logic               w_abort;
   logic               w_busy;
   logic               w_expire;
   logic               w_leg_end;
   logic               w_turn;
   logic               w_dir_eff;
   logic [FCW_W-1:0]   w_tgt_eff;
   logic [FCW_W:0]     w_sum;
   logic [FCW_W:0]     w_diff;
   logic [FCW_W-1:0]   w_nxt_fcw;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [31:0]        w_rdata;
   logic               w_unused_wdata;

   assign w_wr        = ChipSelect & Write;
   assign w_wr_ctrl   = w_wr & (Address == ADDR_CTRL);
   assign w_wr_status = w_wr & (Address == ADDR_STATUS);
   assign w_start     = w_wr_ctrl & WriteData[CTRL_START];
   assign w_abort     = w_wr_ctrl & WriteData[CTRL_ABORT];
   assign w_busy      = (r_state != ST_IDLE);
   assign w_unused_wdata = ^WriteData[31:24];

   assign fcw      = r_fcw;
   assign run      = r_run;
   assign irq      = r_done & r_irq_en;
   assign ReadData = r_rdata;

   sine_sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .i_clk    (Clk),
      .i_rst    (Reset),
      .i_clear  (r_state != ST_DWELL),
      .i_en     (r_state == ST_DWELL),
      .i_tick   (tick),
      .i_dwell  (r_dwell),
      .o_expire (w_expire)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_cont      <= 1'b0;
         r_pingpong  <= 1'b0;
         r_irq_en    <= 1'b0;
         r_start_fcw <= '0;
         r_stop_fcw  <= '0;
         r_step      <= '0;
         r_dwell     <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_cont     <= WriteData[CTRL_CONT];
            r_pingpong <= WriteData[CTRL_PINGPONG];
            r_irq_en   <= WriteData[CTRL_IRQ_EN];
         end
         // Sweep geometry is frozen while a sweep is in progress.
         if (w_wr && (Address == ADDR_RANGE) && !w_busy) begin
            r_start_fcw <= WriteData[FCW_W-1:0];
            r_stop_fcw  <= WriteData[8 +: FCW_W];
            r_step      <= WriteData[16 +: FCW_W];
         end
         if (w_wr && (Address == ADDR_DWELL) && !w_busy) begin
            r_dwell <= WriteData[DWELL_W-1:0];
         end
      end
   end

   // A ping-pong turnaround reverses direction and retargets in the same
   // STEP cycle, so the endpoint is dwelled on exactly once.
   assign w_leg_end = (r_fcw == r_target) || (r_step == '0);
   assign w_turn    = w_leg_end & r_cont & r_pingpong;
   assign w_dir_eff = w_turn ? ~r_dir : r_dir;
   assign w_tgt_eff = !w_turn ? r_target :
                      ((r_target == r_stop_fcw) ? r_start_fcw : r_stop_fcw);
   assign w_sum     = {1'b0, r_fcw} + {1'b0, r_step};
   assign w_diff    = {1'b0, r_fcw} - {1'b0, r_step};
   assign w_cnt_inc = (&r_sweep_cnt) ? r_sweep_cnt : r_sweep_cnt + CNT_W'(1);

   always_comb begin
      w_nxt_fcw = r_fcw;
      if (w_dir_eff) begin
         if (w_sum[FCW_W] || (w_sum[FCW_W-1:0] > w_tgt_eff)) w_nxt_fcw = w_tgt_eff;
         else                                               w_nxt_fcw = w_sum[FCW_W-1:0];
      end else begin
         if (w_diff[FCW_W] || (w_diff[FCW_W-1:0] < w_tgt_eff)) w_nxt_fcw = w_tgt_eff;
         else                                                 w_nxt_fcw = w_diff[FCW_W-1:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_fcw       <= '0;
         r_target    <= '0;
         r_dir       <= 1'b0;
         r_run       <= 1'b0;
         r_done      <= 1'b0;
         r_sweep_cnt <= '0;
      end else begin
         if (w_wr_status && WriteData[STAT_DONE]) r_done <= 1'b0;
         if (w_abort) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: if (w_start) r_state <= ST_LOAD;
               ST_LOAD: begin
                  r_fcw    <= r_start_fcw;
                  r_dir    <= (r_stop_fcw >= r_start_fcw);
                  r_target <= r_stop_fcw;
                  r_run    <= 1'b1;
                  r_state  <= ST_DWELL;
               end
               ST_DWELL: if (w_expire) r_state <= ST_STEP;
               ST_STEP: begin
                  if (w_leg_end) begin
                     r_sweep_cnt <= w_cnt_inc;
                     if (!r_cont) begin
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                     end else if (!r_pingpong) begin
                        r_state <= ST_LOAD;
                     end else begin
                        r_dir    <= w_dir_eff;
                        r_target <= w_tgt_eff;
                        r_fcw    <= w_nxt_fcw;
                        r_state  <= ST_DWELL;
                     end
                  end else begin
                     r_fcw   <= w_nxt_fcw;
                     r_state <= ST_DWELL;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
         if (w_wr_status && WriteData[STAT_CNT_CLR]) r_sweep_cnt <= '0;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (Address)
         ADDR_CTRL: begin
            w_rdata[CTRL_CONT]     = r_cont;
            w_rdata[CTRL_PINGPONG] = r_pingpong;
            w_rdata[CTRL_IRQ_EN]   = r_irq_en;
         end
         ADDR_RANGE: begin
            w_rdata[FCW_W-1:0]  = r_start_fcw;
            w_rdata[8 +: FCW_W]  = r_stop_fcw;
            w_rdata[16 +: FCW_W] = r_step;
         end
         ADDR_DWELL: w_rdata[DWELL_W-1:0] = r_dwell;
         default: begin
            w_rdata[STAT_BUSY]   = w_busy;
            w_rdata[STAT_DONE]   = r_done;
            w_rdata[8 +: FCW_W]  = r_fcw;
            w_rdata[16 +: CNT_W] = r_sweep_cnt;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset)                  r_rdata <= '0;
      else if (ChipSelect && Read) r_rdata <= w_rdata;
   end

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Self-checking bench for sine_sweep_ctrl: directed sweeps plus random
// sweeps compared tick by tick against a point-list model of the sweep.
module tb_sine_sweep_ctrl;

   localparam logic [1:0] A_CTRL = 2'd0, A_RANGE = 2'd1, A_DWELL = 2'd2, A_STATUS = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, wr, rd;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        tick;
   logic [7:0]  fcw;
   logic        run;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;
   int legs;
   int last_fcw;
   logic [7:0] exp_q[$];
   logic       exp_end_q[$];

   always #5 clk = ~clk;

   sine_sweep_ctrl dut (
      .Clk        (clk),
      .Reset      (rst),
      .ChipSelect (cs),
      .Write      (wr),
      .Read       (rd),
      .Address    (addr),
      .WriteData  (wdata),
      .ReadData   (rdata),
      .tick       (tick),
      .fcw        (fcw),
      .run        (run),
      .irq        (irq)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      d = rdata;
   endtask

   function automatic logic [31:0] status_word(input int cnt, input int f, input int done, input int busy);
      return (32'(cnt) << 16) | (32'(f) << 8) | (32'(done) << 1) | 32'(busy);
   endfunction

   // Expected per-tick fcw list: each sweep point repeated max(dwell,1) times,
   // with a flag on the final tick of every leg.
   task automatic build_exp(input int start, input int stop, input int step, input int dwell,
                            input bit cont, input bit pp, input int min_ticks);
      int d, cur, tgt, leg, p, from;
      int pts[$];
      exp_q.delete();
      exp_end_q.delete();
      d   = (dwell == 0) ? 1 : dwell;
      leg = 0;
      cur = start;
      do begin
         pts.delete();
         from = (leg == 0 || !pp) ? start : cur;
         tgt  = (leg == 0 || !pp) ? stop : ((leg % 2 == 1) ? start : stop);
         p = from;
         pts.push_back(p);
         while (p != tgt && step != 0) begin
            if (tgt >= from) p = (p + step > tgt) ? tgt : p + step;
            else             p = (p - step < tgt) ? tgt : p - step;
            pts.push_back(p);
         end
         if (leg != 0 && pp) begin
            void'(pts.pop_front());
            if (pts.size() == 0) pts.push_back(cur);
         end
         for (int i = 0; i < pts.size(); i++) begin
            for (int r = 0; r < d; r++) begin
               exp_q.push_back(8'(pts[i]));
               exp_end_q.push_back((i == pts.size() - 1) && (r == d - 1));
            end
         end
         cur = pts[pts.size() - 1];
         leg++;
      end while (cont && exp_q.size() < min_ticks);
   endtask

   task automatic run_ticks(input int n, input int gap);
      logic [7:0] e;
      logic       f;
      for (int i = 0; i < n; i++) begin
         repeat (gap - 1) @(negedge clk);
         e = exp_q.pop_front();
         f = exp_end_q.pop_front();
         check_eq($sformatf("tick%0d_fcw", i), {24'd0, fcw}, {24'd0, e});
         check_eq($sformatf("tick%0d_run", i), {31'd0, run}, 32'd1);
         last_fcw = e;
         if (f) legs++;
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   task automatic start_sweep(input int start, input int stop, input int step, input int dwell,
                              input bit cont, input bit pp, input bit ien, input int n_cont);
      bus_write(A_STATUS, 32'h6);
      bus_write(A_RANGE, (32'(step) << 16) | (32'(stop) << 8) | 32'(start));
      bus_write(A_DWELL, 32'(dwell));
      build_exp(start, stop, step, dwell, cont, pp, n_cont + 1);
      bus_write(A_CTRL, (32'(ien) << 4) | (32'(pp) << 3) | (32'(cont) << 2) | 32'h1);
      clk_wait(2);
      legs = 0;
   endtask

   task automatic do_sweep(input int start, input int stop, input int step, input int dwell,
                           input bit cont, input bit pp, input bit ien, input int n_cont,
                           input int gap);
      logic [31:0] v;
      logic [7:0]  nxt;
      start_sweep(start, stop, step, dwell, cont, pp, ien, n_cont);
      if (!cont) begin
         run_ticks(exp_q.size(), gap);
         clk_wait(4);
         check_eq("end_run", {31'd0, run}, 32'd0);
         check_eq("end_irq", {31'd0, irq}, {31'd0, ien});
         check_eq("end_fcw", {24'd0, fcw}, 32'(last_fcw));
         bus_read(A_STATUS, v);
         check_eq("end_status", v, status_word(1, last_fcw, 1, 0));
      end else begin
         run_ticks(n_cont, gap);
         clk_wait(4);
         nxt = exp_q[0];
         bus_read(A_STATUS, v);
         check_eq("cont_status", v, status_word(legs, nxt, 0, 1));
         bus_write(A_CTRL, 32'h2);
         check_eq("abort_run", {31'd0, run}, 32'd0);
         bus_read(A_STATUS, v);
         check_eq("abort_status", v, status_word(legs, nxt, 0, 0));
      end
   endtask

   initial begin
      logic [31:0] v;
      int s0, s1, st, dw, mode;
      bit ien;
      rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0; tick = 1'b0;
      clk_wait(3);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_fcw", {24'd0, fcw}, 32'd0);
      check_eq("rst_run", {31'd0, run}, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         bus_read(2'(a), v);
         check_eq($sformatf("rst_reg%0d", a), v, 32'd0);
      end

      // 4 -> 10 step 2, dwell 3, single shot with interrupt
      do_sweep(4, 10, 2, 3, 1'b0, 1'b0, 1'b1, 0, 50);
      bus_read(A_CTRL, v);
      check_eq("ctrl_readback", v, 32'h10);
      bus_write(A_STATUS, 32'h2);
      check_eq("irq_cleared", {31'd0, irq}, 32'd0);
      bus_read(A_STATUS, v);
      check_eq("done_cleared", v, status_word(1, 10, 0, 0));

      // 10 -> 3 step 4, clamped final point
      do_sweep(10, 3, 4, 1, 1'b0, 1'b0, 1'b0, 0, 8);

      // continuous ping-pong 0 <-> 250 step 8
      do_sweep(0, 250, 8, 1, 1'b1, 1'b1, 1'b0, 70, 8);

      // abort while dwelling at fcw 6; RANGE write while busy is dropped
      start_sweep(4, 10, 2, 3, 1'b0, 1'b0, 1'b0, 0);
      run_ticks(3, 8);
      clk_wait(3);
      bus_write(A_RANGE, 32'h0005_2001);
      bus_write(A_CTRL, 32'h2);
      check_eq("abort6_run", {31'd0, run}, 32'd0);
      check_eq("abort6_fcw", {24'd0, fcw}, 32'd6);
      bus_read(A_STATUS, v);
      check_eq("abort6_status", v, status_word(0, 6, 0, 0));
      bus_read(A_RANGE, v);
      check_eq("range_locked", v, 32'h0002_0A04);

      // step 0 / dwell 0: a single one-tick point
      do_sweep(7, 200, 0, 0, 1'b0, 1'b0, 1'b0, 0, 8);
      bus_write(A_CTRL, 32'h3);
      clk_wait(3);
      check_eq("start_abort_run", {31'd0, run}, 32'd0);
      bus_read(A_STATUS, v);
      check_eq("start_abort_busy", v & 32'h1, 32'd0);

      // reset in the middle of a sweep
      start_sweep(20, 90, 5, 2, 1'b1, 1'b0, 1'b1, 10);
      run_ticks(5, 8);
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_fcw", {24'd0, fcw}, 32'd0);
      check_eq("midrst_run", {31'd0, run}, 32'd0);
      rst = 1'b0;
      bus_read(A_STATUS, v);
      check_eq("midrst_status", v, 32'd0);
      bus_read(A_RANGE, v);
      check_eq("midrst_range", v, 32'd0);

      // random sweeps
      for (int k = 0; k < 10; k++) begin
         s0   = $urandom_range(0, 255);
         s1   = $urandom_range(0, 255);
         st   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 64);
         dw   = $urandom_range(0, 3);
         mode = $urandom_range(0, 2);
         ien  = 1'($urandom_range(0, 1));
         do_sweep(s0, s1, st, dw, mode != 0, mode == 2, ien, 40, 8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
